// File: rtl/dvsd_cmp_search.sv
// Successive-approximation search of a 4-bit value via external comparator flags.
// Define DVSD_CMP_SEARCH_SETTLE_EN to insert a SETTLE cycle after each probe update.
module dvsd_cmp_search (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       less_than,
   input  logic       equal_to,
   input  logic       greater_than,
   output logic [3:0] probe_out,
   output logic       busy,
   output logic       done,
   output logic [3:0] result,
   output logic       err
);

`ifdef DVSD_CMP_SEARCH_SETTLE_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PROBE  = 2'd1,
      S_DONE   = 2'd2,
      S_SETTLE = 2'd3
   } state_t;
   localparam state_t S_UPD = S_SETTLE;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PROBE = 2'd1,
      S_DONE  = 2'd2
   } state_t;
   localparam state_t S_UPD = S_PROBE;
`endif

   state_t     r_state;
   logic [3:0] r_acc;
   logic [1:0] r_k;
   logic [3:0] r_probe;
   logic [3:0] r_result;
   logic       r_err;

   state_t     w_state_nx;
   logic [3:0] w_acc_nx;
   logic [1:0] w_k_nx;
   logic [3:0] w_probe_nx;
   logic [3:0] w_result_nx;
   logic       w_err_nx;

   logic [2:0] w_flags;
   logic       w_onehot;
   logic [3:0] w_acc_kept;
   logic [1:0] w_k_dn;
   logic [3:0] w_bit_dn;

   assign w_flags  = {less_than, equal_to, greater_than};
   assign w_onehot = (w_flags == 3'b100) ||
                     (w_flags == 3'b010) ||
                     (w_flags == 3'b001);

   // acc never holds bit k yet, so "clear bit k" is simply the old acc
   assign w_acc_kept = greater_than ? r_probe : r_acc;
   assign w_k_dn     = r_k - 2'd1;
   assign w_bit_dn   = 4'b0001 << w_k_dn;

   always_comb begin
      w_state_nx  = r_state;
      w_acc_nx    = r_acc;
      w_k_nx      = r_k;
      w_probe_nx  = r_probe;
      w_result_nx = r_result;
      w_err_nx    = r_err;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_acc_nx   = 4'b0000;
               w_k_nx     = 2'd3;
               w_probe_nx = 4'b1000;
               w_state_nx = S_UPD;
            end
         end
         S_PROBE: begin
            if (!w_onehot) begin
               w_result_nx = r_probe;
               w_err_nx    = 1'b1;
               w_state_nx  = S_DONE;
            end else if (equal_to) begin
               w_result_nx = r_probe;
               w_err_nx    = 1'b0;
               w_state_nx  = S_DONE;
            end else if (r_k == 2'd0) begin
               w_acc_nx    = w_acc_kept;
               w_result_nx = w_acc_kept;
               w_err_nx    = 1'b0;
               w_state_nx  = S_DONE;
            end else begin
               w_acc_nx   = w_acc_kept;
               w_k_nx     = w_k_dn;
               w_probe_nx = w_acc_kept | w_bit_dn;
               w_state_nx = S_UPD;
            end
         end
`ifdef DVSD_CMP_SEARCH_SETTLE_EN
         S_SETTLE: w_state_nx = S_PROBE;
`endif
         S_DONE: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= 4'b0000;
         r_k      <= 2'd3;
         r_probe  <= 4'b0000;
         r_result <= 4'b0000;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_acc    <= w_acc_nx;
         r_k      <= w_k_nx;
         r_probe  <= w_probe_nx;
         r_result <= w_result_nx;
         r_err    <= w_err_nx;
      end
   end

   assign probe_out = r_probe;
   assign result    = r_result;
   assign err       = r_err;
   assign done      = (r_state == S_DONE);
`ifdef DVSD_CMP_SEARCH_SETTLE_EN
   assign busy      = (r_state == S_PROBE) || (r_state == S_SETTLE);
`else
   assign busy      = (r_state == S_PROBE);
`endif

endmodule
